// File: rtl/nn_cfg_pkg.sv
// Shared network configuration for the weight streamer: default shape,
// per-layer sizing helper and the sequencer state encoding.
package nn_cfg_pkg;

    localparam int WW_DEF       = 16;
    localparam int N_LAYERS_DEF = 3;
    localparam int SHAPE_DEF [N_LAYERS_DEF] = '{49, 37, 4};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Words occupied by one weight layer: each neuron stores its bias plus fan-in weights.
    function automatic int layer_size(input int fanin, input int fanout);
        return fanout * (fanin + 1);
    endfunction

    function automatic int shape_max();
        int m;
        m = 1;
        for (int i = 0; i < N_LAYERS_DEF; i++) begin
            if (SHAPE_DEF[i] > m) m = SHAPE_DEF[i];
        end
        return m;
    endfunction

    localparam int MAX_SHAPE_DEF = shape_max();

endpackage

// File: rtl/nn_weight_ram.sv
// Single-port synchronous weight RAM with one-cycle registered read.
module nn_weight_ram #(
    parameter int DEPTH = 2048,
    parameter int WW    = 16,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [WW-1:0] wdata,
    output logic [WW-1:0] rdata
);

    logic [WW-1:0] mem [DEPTH];

    // Write port and registered read share the single address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/nn_weight_streamer.sv
// Walks one weight layer of the RAM and streams bias + fan-in weights per neuron
// over valid/ready, through a two-entry credit-checked output buffer.
module nn_weight_streamer
    import nn_cfg_pkg::*;
#(
    parameter int WW       = WW_DEF,
    parameter int N_LAYERS = N_LAYERS_DEF,
    parameter int SHAPE [N_LAYERS] = SHAPE_DEF,
    parameter int DEPTH    = 2048,
    parameter int AW       = $clog2(DEPTH),
    parameter int NW       = $clog2(MAX_SHAPE_DEF),
    parameter int LW       = $clog2(N_LAYERS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [WW-1:0] wr_data,
    input  logic          start,
    input  logic [LW-1:0] layer_idx,
    output logic          busy,
    output logic          err,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [WW-1:0] m_data,
    output logic          m_is_bias,
    output logic [NW-1:0] m_neuron,
    output logic          m_last_in_neuron,
    output logic          m_last,
    output logic          done
);

    function automatic int base_of(input int k);
        int acc;
        acc = 0;
        for (int j = 0; j < k; j++) begin
            acc += layer_size(SHAPE[j], SHAPE[j+1]);
        end
        return acc;
    endfunction

    if (base_of(N_LAYERS - 1) > DEPTH) begin : g_depth_chk
        $error("nn_weight_streamer: DEPTH too small for network shape");
    end

    typedef struct packed {
        logic [WW-1:0] data;
        logic          is_bias;
        logic [NW-1:0] neuron;
        logic          lin;
        logic          last;
    } beat_t;

    localparam int TAB = 2 ** LW;

    logic [AW-1:0] base_tab  [TAB];
    logic [NW:0]   fanin_tab [TAB];
    logic [NW-1:0] lastn_tab [TAB];

    for (genvar k = 0; k < TAB; k++) begin : g_tab
        if (k < N_LAYERS - 1) begin : g_valid
            assign base_tab[k]  = AW'(base_of(k));
            assign fanin_tab[k] = (NW+1)'(SHAPE[k]);
            assign lastn_tab[k] = NW'(SHAPE[k+1] - 1);
        end else begin : g_unused
            assign base_tab[k]  = '0;
            assign fanin_tab[k] = '0;
            assign lastn_tab[k] = '0;
        end
    end

    state_t        state_r, state_nx;
    logic          idle_s, run_s;
    logic          start_ok_s, start_bad_s;
    logic          issue_s, pop_s, final_addr_s;
    logic [2:0]    occ_s;
    logic [AW-1:0] addr_r, ram_addr_s;
    logic [NW-1:0] neuron_r, lastn_r;
    logic [NW:0]   word_r, fanin_r;
    logic          pend_r, pend_bias_r, pend_lin_r, pend_last_r;
    logic [NW-1:0] pend_neuron_r;
    logic [WW-1:0] ram_rdata_s;
    beat_t         slot0_r, slot1_r, in_beat_s;
    logic [1:0]    count_r;
    logic          err_r, done_r, busy_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_nx = ST_RUN;
                else            state_nx = ST_IDLE;
            end
            ST_RUN: begin
                if (issue_s && final_addr_s) state_nx = ST_DRAIN;
                else                         state_nx = ST_RUN;
            end
            ST_DRAIN: begin
                if (pop_s && slot0_r.last) state_nx = ST_IDLE;
                else                       state_nx = ST_DRAIN;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        idle_s = 1'b0;
        run_s  = 1'b0;
        case (state_r)
            ST_IDLE:  idle_s = 1'b1;
            ST_RUN:   run_s  = 1'b1;
            ST_DRAIN: run_s  = 1'b0;
            default:  idle_s = 1'b0;
        endcase
    end

    // Read issue: committed occupancy counts the in-flight read and credits this cycle's pop.
    always_comb begin
        pop_s        = (count_r != 2'd0) && m_ready;
        occ_s        = {1'b0, count_r} + {2'b00, pend_r} - {2'b00, pop_s};
        issue_s      = run_s && (occ_s < 3'd2);
        final_addr_s = (neuron_r == lastn_r) && (word_r == fanin_r);
        start_ok_s   = start && idle_s && (layer_idx < LW'(N_LAYERS - 1));
        start_bad_s  = start && idle_s && !(layer_idx < LW'(N_LAYERS - 1));
        ram_addr_s   = idle_s ? wr_addr : addr_r;
    end

    nn_weight_ram #(
        .DEPTH (DEPTH),
        .WW    (WW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en && idle_s),
        .addr  (ram_addr_s),
        .wdata (wr_data),
        .rdata (ram_rdata_s)
    );

    // Address, neuron and word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= '0;
            neuron_r <= '0;
            word_r   <= '0;
            fanin_r  <= '0;
            lastn_r  <= '0;
        end else if (start_ok_s) begin
            addr_r   <= base_tab[layer_idx];
            neuron_r <= '0;
            word_r   <= '0;
            fanin_r  <= fanin_tab[layer_idx];
            lastn_r  <= lastn_tab[layer_idx];
        end else if (issue_s) begin
            addr_r <= addr_r + AW'(1);
            if (word_r == fanin_r) begin
                word_r   <= '0;
                neuron_r <= neuron_r + NW'(1);
            end else begin
                word_r <= word_r + (NW+1)'(1);
            end
        end
    end

    // Flags computed at issue travel alongside the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r        <= 1'b0;
            pend_bias_r   <= 1'b0;
            pend_neuron_r <= '0;
            pend_lin_r    <= 1'b0;
            pend_last_r   <= 1'b0;
        end else begin
            pend_r <= issue_s;
            if (issue_s) begin
                pend_bias_r   <= (word_r == '0);
                pend_neuron_r <= neuron_r;
                pend_lin_r    <= (word_r == fanin_r);
                pend_last_r   <= final_addr_s;
            end
        end
    end

    // Assemble the beat arriving from the RAM.
    always_comb begin
        in_beat_s         = '0;
        in_beat_s.data    = ram_rdata_s;
        in_beat_s.is_bias = pend_bias_r;
        in_beat_s.neuron  = pend_neuron_r;
        in_beat_s.lin     = pend_lin_r;
        in_beat_s.last    = pend_last_r;
    end

    // Two-entry shift buffer; slot0 is always the presented beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_r <= '0;
            slot1_r <= '0;
            count_r <= 2'd0;
        end else begin
            case ({pend_r, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) slot0_r <= in_beat_s;
                    else                 slot1_r <= in_beat_s;
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        slot0_r <= in_beat_s;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= in_beat_s;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

    // Status pulses and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r  <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            err_r  <= start_bad_s;
            done_r <= pop_s && slot0_r.last;
            busy_r <= (state_nx != ST_IDLE);
        end
    end

    assign busy             = busy_r;
    assign err              = err_r;
    assign done             = done_r;
    assign m_valid          = (count_r != 2'd0);
    assign m_data           = slot0_r.data;
    assign m_is_bias        = slot0_r.is_bias;
    assign m_neuron         = slot0_r.neuron;
    assign m_last_in_neuron = slot0_r.lin;
    assign m_last           = slot0_r.last;

endmodule

// File: tb/tb_nn_weight_streamer.sv
// Scoreboard bench for nn_weight_streamer: a reference model queues expected
// beats per layer, a negedge monitor pops and compares on each transfer.
module tb_nn_weight_streamer;

    localparam int WW = 16, N_LAYERS = 3, DEPTH = 2048, AW = 11, NW = 6, LW = 2;
    localparam int SHAPE [N_LAYERS] = '{49, 37, 4};

    typedef struct {
        logic [WW-1:0] data;
        bit            is_bias;
        int            neuron;
        bit            lin;
        bit            last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [WW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [LW-1:0] layer_idx = '0;
    logic          busy, err, m_valid, m_is_bias, m_last_in_neuron, m_last, done;
    logic          m_ready = 1'b1;
    logic [WW-1:0] m_data;
    logic [NW-1:0] m_neuron;

    logic [WW-1:0] mem_model [DEPTH];
    exp_t          exp_q [$];
    int            cyc = 0, errors = 0, checks = 0;
    int            t_start = 0, exp_b = 0, beats_seen = 0, last_xfer_cyc = -10;
    bit            first_pending = 0, full_rate = 0, rand_mode = 0;

    nn_weight_streamer dut (
        .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .start (start), .layer_idx (layer_idx), .busy (busy), .err (err),
        .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data), .m_is_bias (m_is_bias),
        .m_neuron (m_neuron), .m_last_in_neuron (m_last_in_neuron), .m_last (m_last), .done (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: layer k starts after all earlier layers; each neuron is bias then fan-in weights.
    task automatic build(input int k);
        int base, fanin, nn;
        exp_t e;
        base = 0;
        for (int j = 0; j < k; j++) base += SHAPE[j+1] * (SHAPE[j] + 1);
        fanin = SHAPE[k];
        nn    = SHAPE[k+1];
        exp_b = nn * (fanin + 1);
        for (int n = 0; n < nn; n++) begin
            for (int w = 0; w <= fanin; w++) begin
                e.data    = mem_model[base + n * (fanin + 1) + w];
                e.is_bias = (w == 0);
                e.neuron  = n;
                e.lin     = (w == fanin);
                e.last    = (n == nn - 1) && (w == fanin);
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit          stall_prev;
        logic [24:0] held, cur;
        exp_t        e;
        stall_prev = 0;
        held = '0;
        forever begin
            @(negedge clk);
            cur = {m_data, m_is_bias, m_neuron, m_last_in_neuron, m_last};
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_outputs", 32'(cur), 32'(held));
                end
                if (m_valid && first_pending) begin
                    check("first_latency", 32'(cyc), 32'(t_start + 2));
                    first_pending = 0;
                end
                if (done || cyc == last_xfer_cyc + 1)
                    check("done_pulse", 32'(done), 32'(cyc == last_xfer_cyc + 1));
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: actual data=%0h expected no beat", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", 32'(m_data), 32'(e.data));
                        check("is_bias", 32'(m_is_bias), 32'(e.is_bias));
                        check("neuron", 32'(m_neuron), 32'(e.neuron));
                        check("last_in_neuron", 32'(m_last_in_neuron), 32'(e.lin));
                        check("last", 32'(m_last), 32'(e.last));
                    end
                    beats_seen++;
                    if (m_last && full_rate) check("last_timing", 32'(cyc), 32'(t_start + exp_b + 1));
                    if (m_last) last_xfer_cyc = cyc;
                end
                stall_prev = m_valid && !m_ready;
                held = cur;
            end
        end
    end

    task automatic run_layer(input int k, input bit rr, input bit do_wr, input int wa,
                             input logic [WW-1:0] wd, input int poke);
        bit got;
        if (do_wr) mem_model[wa] = wd;
        build(k);
        @(posedge clk);
        #1;
        start = 1'b1; layer_idx = LW'(k);
        wr_en = do_wr; wr_addr = AW'(wa); wr_data = wd;
        rand_mode = rr; full_rate = !rr;
        t_start = cyc + 1; first_pending = 1;
        @(posedge clk);
        #1;
        start = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("busy_run", 32'(busy), 32'd1);
        got = 0;
        for (int i = 0; i < 8000 && !got; i++) begin
            @(posedge clk);
            #1;
            if (i == poke) begin
                wr_en = 1'b1; wr_addr = AW'(5); wr_data = 16'h7FFF; start = 1'b1; layer_idx = LW'(1);
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            if (done) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: actual no done expected done within 8000 cycles");
        end
        check("busy_after_done", 32'(busy), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        rand_mode = 0;
        full_rate = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_flags", 32'({m_is_bias, m_neuron, m_last_in_neuron, m_last, err, done}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            @(posedge clk);
            #1;
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = WW'(a);
            mem_model[a] = WW'(a);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;

        run_layer(0, 0, 0, 0, '0, -1);
        run_layer(1, 0, 1, 1850, 16'h1234, -1);

        for (int idx = 2; idx < 4; idx++) begin
            @(posedge clk);
            #1;
            start = 1'b1; layer_idx = LW'(idx);
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            check("err_pulse", 32'(err), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
            check("err_valid", 32'(m_valid), 32'd0);
            @(negedge clk);
            check("err_clear", 32'(err), 32'd0);
            check("err_idle_valid", 32'(m_valid), 32'd0);
        end

        run_layer(0, 1, 0, 0, '0, 300);

        for (int r = 0; r < 20; r++) begin
            int a;
            logic [WW-1:0] d;
            a = $urandom_range(1850, 2001);
            d = WW'($urandom);
            @(posedge clk);
            #1;
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
            mem_model[a] = d;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        run_layer(1, 1, 0, 0, '0, -1);

        build(0);
        beats_seen = 0;
        @(posedge clk);
        #1;
        start = 1'b1; layer_idx = LW'(0); t_start = cyc + 1; first_pending = 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3000 && beats_seen < 100; i++) @(negedge clk);
        check("abort_reached", 32'(beats_seen >= 100), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_data", 32'(m_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_flags", 32'({m_is_bias, m_neuron, m_last_in_neuron, m_last, err, done}), 32'd0);
        exp_q.delete();
        first_pending = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_layer(0, 0, 0, 0, '0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nn_weight_streamer.md
# nn_weight_streamer

Parametrised weight store and sequencer for the fixed-point neuron datapath. Weights and biases live in a runtime-loadable single-port RAM rather than as elaboration-time constants. On a start request the block walks one network layer and streams, for each neuron, its bias followed by its fan-in weights over a valid/ready interface to the neuron units. Per-layer base addresses are derived at elaboration from the network shape, so the same RTL serves any layer count and size.

## Interface
Parameters:
- WW, 16: signed weight/bias word width
- N_LAYERS, 3: layer count including the input layer
- SHAPE, {49,37,4}: neurons per layer, input layer first; integer array of N_LAYERS entries
- DEPTH, 2048: RAM words; must be ≥ sum over l≥1 of SHAPE[l]·(SHAPE[l-1]+1); elaboration error otherwise
- AW, $clog2(DEPTH): address width
- NW, $clog2(max SHAPE): neuron index width
- LW, $clog2(N_LAYERS): layer index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  RAM write strobe; accepted only in IDLE
- wr_addr  in  AW  write address
- wr_data  in  WW  write word
- start  in  1  start pulse; sampled in IDLE only
- layer_idx  in  LW  weight layer to stream (0 = first hidden layer)
- busy  out  1  high in any state except IDLE
- err  out  1  one-cycle pulse: start with layer_idx ≥ N_LAYERS-1
- m_valid  out  1  stream beat valid
- m_ready  in  1  downstream ready
- m_data  out  WW  weight or bias
- m_is_bias  out  1  beat is a neuron's bias (first beat of the neuron)
- m_neuron  out  NW  neuron index within the layer
- m_last_in_neuron  out  1  final weight of the neuron
- m_last  out  1  final beat of the layer
- done  out  1  one-cycle pulse after the m_last beat transfers

## Operation
- Memory layout per layer l (weight layer k=l-1): BASE[k] = sum of SIZE[j] for j<k, where SIZE[j] = SHAPE[j+1]·(SHAPE[j]+1). Neuron n occupies BASE[k] + n·(FANIN+1); word 0 is the bias, then FANIN = SHAPE[k] weights.
- States: IDLE, RUN, DRAIN.
- IDLE: wr_en writes RAM. start with a valid layer enters RUN and loads the address counter with BASE[layer_idx]. If layer_idx is invalid, err pulses and the block stays in IDLE. If start and wr_en coincide, the write completes and the start is also taken.
- RUN: issue one RAM read per cycle while the two-entry output buffer has room counting in-flight reads. Counters track the neuron index and the word index within the neuron. Flags are computed at read issue and travel with the data. After the last address is issued, go to DRAIN.
- DRAIN: wait until the buffer empties and the last beat transfers, then pulse done and return to IDLE.
- wr_en outside IDLE is ignored: the RAM is not modified.
- start outside IDLE is ignored.
- m_data, flags and m_neuron must stay stable while m_valid=1 and m_ready=0.

## Timing
- RAM read latency is 1 cycle (synchronous read).
- start accepted at edge t: first m_valid=1 after edge t+2, carrying the bias of neuron 0.
- With m_ready held at 1: one beat per cycle, no bubbles. A layer of B beats shows m_last after edge t+B+1 and done one cycle after the m_last transfer.
- Backpressure: after m_ready rises, throughput recovers to 1 beat/cycle within 1 cycle. No beat is lost or duplicated.
- Reset values: busy=0, err=0, m_valid=0, m_data=0, all flags 0, m_neuron=0, done=0, state IDLE, buffer empty.
- Reset mid-stream aborts immediately. RAM contents are not cleared and are undefined only for a write in flight at the reset edge.

## Structure
- A shared package `nn_cfg_pkg` holds SHAPE, N_LAYERS, WW, the SIZE/BASE constant functions and the state enum. The package replaces hardcoded weight and position tables.
- Sub-module `nn_weight_ram`: single-port synchronous RAM (DEPTH×WW) with a write port and registered read.
- The two-entry output buffer stays inline.

## Test plan
- Load RAM[a]=a for all a, start layer 0, m_ready=1 → 1850 beats, data 0..1849, m_is_bias at data 0,50,…,1800, m_neuron 0..36, m_last on data 1849, done one cycle later.
- Start layer 1 → 152 beats, data 1850..2001, m_neuron 0..3, m_last_in_neuron on 1887,1925,1963,2001.
- Layer 0 with random m_ready at 50% → same 1850-value sequence in order, stable while stalled.
- start with layer_idx=2 → err pulse, busy stays 0, no m_valid.
- wr_en to addr 5 with value 0x7FFF during RUN → a subsequent layer 0 stream still shows data 5 at beat 5.
- rst_n low at beat 100 of layer 0 → all outputs 0 next cycle; restart streams from bias 0 with RAM intact.
